// File: rtl/rom_ctrl_pkg.sv
// rom_ctrl_pkg: shared state type and width defaults for the ROM read controller
package rom_ctrl_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; a tie goes to the requester not granted last
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic [1:0] gnt
);
  logic last_q;
  always_comb begin
    gnt[0] = req[0] & (~req[1] | last_q);
    gnt[1] = req[1] & (~req[0] | ~last_q);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) last_q <= 1'b1;
    else if (grant_en && |req) last_q <= gnt[1];
endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: two-port round-robin read sequencer for an asynchronous ROM
module rom_read_arbiter
  import rom_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oeb,
  input  logic [DATA_W-1:0] rom_data
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gid_q, gid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              oeb_q, ack0_q, ack1_q;
  logic [1:0]        gnt;
  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({req1, req0}),
    .grant_en (state_q == IDLE),
    .gnt      (gnt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = SETUP;
        gid_d   = gnt[1];
        addr_d  = gnt[1] ? addr1 : addr0;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      ACCESS: if (cnt_q == '0) begin
        state_d = DONE;
        rdata_d = rom_data;
      end else cnt_d = cnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // Pin-facing outputs are registered from next state so they change cleanly on the edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gid_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      oeb_q   <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      oeb_q   <= state_d != ACCESS;
      ack0_q  <= state_d == DONE && !gid_d;
      ack1_q  <= state_d == DONE && gid_d;
    end
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign busy     = state_q != IDLE;
  assign rom_addr = addr_q;
  assign rom_oeb  = oeb_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: directed and random reads checked against a transaction timeline model
module tb_rom_read_arbiter;
  localparam int W = 2;
  logic        clk = 0, rst = 0;
  logic        req0 = 0, req1 = 0;
  logic [14:0] addr0 = 0, addr1 = 0;
  logic        ack0, ack1, busy, rom_oeb;
  logic [7:0]  rdata, rom_data;
  logic [14:0] rom_addr;
  logic        b_req1 = 0;
  logic [14:0] b_addr1 = 0;
  logic        b_ack0, b_ack1, b_busy, b_oeb;
  logic [7:0]  b_rdata, b_rom_data;
  logic [14:0] b_rom_addr;
  int          checks = 0, failures = 0;
  int          k = 0;
  logic        mlast = 1, mwin = 0;
  logic [14:0] maddr = 0;
  logic [7:0]  mrdata = 0;
  logic        prev_low = 0;
  logic [14:0] prev_addr = 0;
  int          lat, who, lowc, order[4], nack;
  logic [7:0]  d, oebs;
  always #5 clk = ~clk;
  assign rom_data   = rom_oeb ? 8'hxx : rom_addr[7:0] ^ 8'hA5;
  assign b_rom_data = b_oeb ? 8'hxx : b_rom_addr[7:0] ^ 8'hA5;
  rom_read_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .rdata(rdata), .busy(busy),
    .rom_addr(rom_addr), .rom_oeb(rom_oeb), .rom_data(rom_data)
  );
  rom_read_arbiter #(.WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .req0(1'b0), .addr0(15'h0), .ack0(b_ack0),
    .req1(b_req1), .addr1(b_addr1), .ack1(b_ack1), .rdata(b_rdata), .busy(b_busy),
    .rom_addr(b_rom_addr), .rom_oeb(b_oeb), .rom_data(b_rom_data)
  );
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // k = cycles since the grant edge; 0 means no transaction in flight
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; mlast = 1; maddr = '0; mrdata = '0;
    end else if (k == W + 2) k = 0;
    else if (k > 0) begin
      k++;
      if (k == W + 2) mrdata = maddr[7:0] ^ 8'hA5;
    end else if (req0 || req1) begin
      mwin = (req0 && req1) ? !mlast : req1;
      mlast = mwin;
      maddr = mwin ? addr1 : addr0;
      k = 1;
    end
  end
  always @(negedge clk) begin
    check("busy", busy, k > 0);
    check("rom_oeb", rom_oeb, !(k >= 2 && k <= W + 1));
    check("ack0", ack0, k == W + 2 && !mwin);
    check("ack1", ack1, k == W + 2 && mwin);
    check("ack_excl", ack0 & ack1, 0);
    check("rdata", rdata, mrdata);
    check("rom_addr", rom_addr, maddr);
    if (prev_low && !rom_oeb) check("addr_stable", rom_addr, prev_addr);
    prev_low = !rom_oeb;
    prev_addr = rom_addr;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_until_ack(output int l, output int w, output logic [7:0] dv, output logic [7:0] ob);
    l = 0; w = -1; ob = {7'b0, rom_oeb};
    while (w < 0 && l < 30) begin
      tick(); l++;
      ob = {ob[6:0], rom_oeb};
      if (ack0) w = 0;
      else if (ack1) w = 1;
    end
    dv = rdata;
    if (w < 0) check("ack_timeout", 0, 1);
  endtask
  function automatic logic [14:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom());
  endfunction
  initial begin
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("reset_busy", busy, 0);
    check("reset_oeb", rom_oeb, 1);
    check("reset_rdata", rdata, 0);
    tick();
    req0 = 1; addr0 = 15'h0001;
    run_until_ack(lat, who, d, oebs);
    req0 = 0;
    check("single_who", who, 0);
    check("single_lat", lat, 4);
    check("single_data", d, 8'hA4);
    check("single_oeb_wave", oebs[4:0], 5'b11001);
    tick(); rst = 1; tick(); rst = 0;
    req0 = 1; addr0 = 15'h0002; req1 = 1; addr1 = 15'h0003;
    run_until_ack(lat, who, d, oebs);
    req0 = 0;
    check("sim_first_who", who, 0);
    check("sim_first_lat", lat, 4);
    check("sim_first_data", d, 8'hA7);
    run_until_ack(lat, who, d, oebs);
    check("sim_second_who", who, 1);
    check("sim_second_gap", lat, 5);
    check("sim_second_data", d, 8'hA6);
    req0 = 1;
    for (int i = 0; i < 4; i++) begin
      run_until_ack(lat, who, d, oebs);
      order[i] = who;
    end
    req0 = 0; req1 = 0;
    for (int i = 0; i < 4; i++) check("contention_order", order[i], i % 2);
    tick(); tick();
    b_req1 = 1; b_addr1 = 15'h7FFF; lat = 0; lowc = 0; who = -1;
    while (who < 0 && lat < 20) begin
      tick(); lat++;
      if (!b_oeb) lowc++;
      if (b_ack1) who = 1;
    end
    b_req1 = 0;
    check("boundary_ack", who, 1);
    check("boundary_lat", lat, 3);
    check("boundary_oeb_low", lowc, 1);
    check("boundary_data", b_rdata, 8'h5A);
    tick();
    req0 = 1; addr0 = 15'h0155;
    tick(); tick();
    check("mid_access_oeb", rom_oeb, 0);
    #2 rst = 1;
    #1;
    check("rst_oeb", rom_oeb, 1);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_busy", busy, 0);
    tick(); rst = 0;
    run_until_ack(lat, who, d, oebs);
    req0 = 0;
    check("rst_reserve_who", who, 0);
    check("rst_reserve_data", d, 8'hF0);
    tick(); tick();
    req0 = 1; addr0 = 15'h0010;
    tick();
    req1 = 1; addr1 = 15'h0020;
    tick();
    req1 = 0;
    run_until_ack(lat, who, d, oebs);
    req0 = 0;
    check("drop_who", who, 0);
    check("drop_data", d, 8'hB5);
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ack1 || busy) nack++;
    end
    check("drop_no_req1_txn", nack, 0);
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (ack0) begin
        req0 = $urandom_range(0, 1) == 1;
        addr0 = rnd_addr();
      end else if (req0 && $urandom_range(0, 15) == 0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; addr0 = rnd_addr();
      end
      if (ack1) begin
        req1 = $urandom_range(0, 1) == 1;
        addr1 = rnd_addr();
      end else if (req1 && $urandom_range(0, 15) == 0) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; addr1 = rnd_addr();
      end
    end
    req0 = 0; req1 = 0;
    repeat (10) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
